approx_mac_accumulator: RTL and testbench

Sequential accumulate stage placed directly downstream of the 16x16 signed approximate multipliers (logarithmic/ROBA family). It consumes one 32-bit signed product per cycle through a valid/ready handshake and sums products into a wide signed accumulator. It emits one registered dot-product result, with term count and overflow flag, when the upstream marks the last term. This turns the combinational multiplier into a streaming approximate MAC for filter and dot-product error evaluation.

---
 rtl/approx_mac_accumulator.sv | 103 ++++++++++
 tb/tb_approx_mac_accumulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mac_accumulator.sv
// Streaming accumulate stage behind a 16x16 approximate multiplier: sums signed
// 32-bit products into a wide accumulator and emits one dot product per in_last.
module approx_mac_accumulator #(
    parameter int ACC_W = 40,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [15:0]      out_cnt,
    output logic             out_ovf
);

    if (ACC_W < 33 || ACC_W > 64) begin : g_bad_acc_w
        $error("approx_mac_accumulator: ACC_W must be in 33..64");
    end

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [ACC_W-1:0] acc;
    logic [15:0]      cnt;
    logic             ovf;
    logic [ACC_W:0]   sum;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_nx;
    logic [15:0]      cnt_nx;
    logic             ovf_nx;
    logic             acc_en;
    logic             close_en;

    // Handshakes: a term transfers on in_valid & in_ready, a result on
    // out_valid & out_ready. in_ready opens whenever the result slot is empty
    // or is being drained this cycle, so back-to-back results need no bubble.
    assign in_ready  = (state_q == EMPTY) | out_ready;
    assign out_valid = (state_q == FULL);
    assign acc_en    = in_valid & in_ready;
    assign close_en  = acc_en & in_last;

    // One guard bit: the top two sum bits disagree exactly on signed overflow.
    assign sum     = {acc[ACC_W-1], acc} + {{(ACC_W-31){in_p[31]}}, in_p};
    assign add_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    assign cnt_nx  = (cnt == 16'hFFFF) ? cnt : 16'(cnt + 16'd1);
    assign ovf_nx  = ovf | add_ovf;

    always_comb begin
        acc_nx = sum[ACC_W-1:0];
        if (SAT && add_ovf) begin
            acc_nx = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            EMPTY:   if (close_en) state_n = FULL;
            FULL:    if (out_ready && !close_en) state_n = EMPTY;
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_acc <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else begin
            state_q <= state_n;
            if (acc_en) begin
                if (in_last) begin
                    out_acc <= acc_nx;
                    out_cnt <= cnt_nx;
                    out_ovf <= ovf_nx;
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                end else begin
                    acc <= acc_nx;
                    cnt <= cnt_nx;
                    ovf <= ovf_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_mac_accumulator.sv
// Bench for approx_mac_accumulator: three configurations driven by one shared
// stream, checked through an expected-result queue against an arithmetic model.
module tb_approx_mac_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_p;
    logic        in_last;
    logic        out_ready;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [39:0] out_acc0;
    logic [32:0] out_acc1, out_acc2;
    logic [15:0] out_cnt0, out_cnt1, out_cnt2;
    logic        out_ovf0, out_ovf1, out_ovf2;

    logic signed [63:0] oacc0, oacc1, oacc2;
    assign oacc0 = 64'($signed(out_acc0));
    assign oacc1 = 64'($signed(out_acc1));
    assign oacc2 = 64'($signed(out_acc2));

    approx_mac_accumulator #(.ACC_W(40), .SAT(1'b1)) u_sat40 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_p(in_p), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
        .out_acc(out_acc0), .out_cnt(out_cnt0), .out_ovf(out_ovf0)
    );

    approx_mac_accumulator #(.ACC_W(33), .SAT(1'b1)) u_sat33 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_p(in_p), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
        .out_acc(out_acc1), .out_cnt(out_cnt1), .out_ovf(out_ovf1)
    );

    approx_mac_accumulator #(.ACC_W(33), .SAT(1'b0)) u_wrap33 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_p(in_p), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_acc(out_acc2), .out_cnt(out_cnt2), .out_ovf(out_ovf2)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [63:0] a0;
        logic [63:0] a1;
        logic [63:0] a2;
        logic [15:0] cnt;
        logic        o0;
        logic        o1;
        logic        o2;
    } res_t;

    res_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    localparam int WS [3] = '{40, 33, 33};
    localparam bit SS [3] = '{1'b1, 1'b1, 1'b0};

    longint m_acc [3];
    bit     m_ovf [3];
    int     m_cnt;
    bit     pending;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Plain integer arithmetic: the true sum, then clamp or fold back into range.
    function automatic longint add_term(input longint a, input longint p, input int w,
                                        input bit sat, output bit ov);
        longint mx, mn, s;
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -mx - 1;
        s  = a + p;
        ov = (s > mx) || (s < mn);
        if (s > mx) s = sat ? mx : s - (longint'(1) << w);
        else if (s < mn) s = sat ? mn : s + (longint'(1) << w);
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic model_take(input logic [31:0] p, input bit last);
        bit   ov;
        res_t r;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = add_term(m_acc[i], longint'($signed(p)), WS[i], SS[i], ov);
            m_ovf[i] = m_ovf[i] | ov;
        end
        if (m_cnt < 65535) m_cnt++;
        if (last) begin
            r.a0  = m_acc[0];
            r.a1  = m_acc[1];
            r.a2  = m_acc[2];
            r.cnt = 16'(m_cnt);
            r.o0  = m_ovf[0];
            r.o1  = m_ovf[1];
            r.o2  = m_ovf[2];
            exp_q.push_back(r);
            model_clear();
        end
    endtask

    // Monitor: samples mid-cycle, before the driver updates the model for the
    // coming edge, so the queue holds exactly the results already loaded.
    always @(negedge clk) begin
        bit   exp_v;
        res_t e;
        exp_v = (exp_q.size() != 0);
        check("out_valid", {61'd0, out_valid0, out_valid1, out_valid2}, {61'd0, {3{exp_v}}});
        check("in_ready", {61'd0, in_ready0, in_ready1, in_ready2},
              {61'd0, {3{!exp_v || out_ready}}});
        if (exp_v) begin
            e = exp_q[0];
            check("acc_sat40", oacc0, e.a0);
            check("acc_sat33", oacc1, e.a1);
            check("acc_wrap33", oacc2, e.a2);
            check("cnt", {16'd0, out_cnt0, out_cnt1, out_cnt2}, {16'd0, e.cnt, e.cnt, e.cnt});
            check("ovf", {61'd0, out_ovf0, out_ovf1, out_ovf2}, {61'd0, e.o0, e.o1, e.o2});
            if (out_ready) void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit v, input logic [31:0] p, input bit last, input bit ordy);
        bit take;
        in_valid  = v;
        in_p      = p;
        in_last   = last;
        out_ready = ordy;
        @(negedge clk);
        #1;
        take = v && (!pending || ordy);
        if (take) model_take(p, last);
        pending = (take && last) ? 1'b1 : (pending && !ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_p      = $urandom;
        in_last   = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        exp_q.delete();
        model_clear();
        pending = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {61'd0, out_valid0, out_valid1, out_valid2}, 64'd0);
        check("rst_out_acc", oacc0 | oacc1 | oacc2, 64'd0);
        check("rst_out_cnt", {16'd0, out_cnt0, out_cnt1, out_cnt2}, 64'd0);
        check("rst_out_ovf", {61'd0, out_ovf0, out_ovf1, out_ovf2}, 64'd0);
        check("rst_in_ready", {61'd0, in_ready0, in_ready1, in_ready2}, 64'd7);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_p();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 2000)) - 32'd1000;
            1:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        in_valid  = 1'b0;
        in_p      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        pending   = 1'b0;
        model_clear();
        do_reset();

        // Basic sum: 100 - 200 + 300
        cyc(1, 32'd100, 0, 1);
        cyc(1, 32'hFFFF_FF38, 0, 1);
        cyc(1, 32'd300, 1, 1);
        cyc(0, 0, 0, 1);

        // Saturation / wrap, then a fresh dot product clears the flag
        cyc(1, 32'h7FFF_FFFF, 0, 1);
        cyc(1, 32'h7FFF_FFFF, 0, 1);
        cyc(1, 32'h7FFF_FFFF, 1, 1);
        cyc(1, 32'hFFFF_FFFB, 1, 1);
        cyc(0, 0, 0, 1);

        // Backpressure: pending result holds while junk is offered
        cyc(1, 32'd7, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, $urandom, 1'($urandom_range(0, 1)), 0);
        cyc(1, 32'd9, 1, 1);
        cyc(0, 0, 0, 1);

        // Back-to-back single-term dot products including -2^31
        cyc(1, 32'h8000_0000, 1, 1);
        cyc(1, 32'd1, 1, 1);
        cyc(0, 0, 0, 1);

        // Reset mid dot product, and reset with a result pending
        cyc(1, 32'd50, 0, 1);
        cyc(1, 32'd60, 0, 1);
        do_reset();
        cyc(1, 32'd70, 1, 1);
        cyc(1, 32'd5, 1, 0);
        do_reset();

        // Term counter saturation
        for (int i = 0; i < 65540; i++) cyc(1, 32'd1, i == 65539, 1);
        cyc(0, 0, 0, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            else cyc($urandom_range(0, 3) != 0, rnd_p(), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) != 0);
        end

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
